rxecrc: RTL and testbench

- Receive-path stage directly downstream of the preamble stripper.
- Consumes the byte stream that remains after the preamble/SFD is removed (destination MAC through FCS).
- Computes Ethernet CRC-32 over the frame, removes the 4 trailing FCS bytes from the forwarded stream, and flags a bad frame on o_err at end of packet.
- Output feeds the hardware-address filter and packet buffer.

---
 rtl/rxecrc_pkg.sv | 12 +
 rtl/rxecrc_byte.sv | 23 ++
 rtl/rxecrc.sv | 97 +++++++++
 tb/tb_rxecrc.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/rxecrc_pkg.sv
// Shared constants for the receive-side Ethernet CRC-32 check and strip stage.
// Also used by the transmit-side CRC generator.
package rxecrc_pkg;

   // Reflected CRC-32 (IEEE 802.3), processed LSB first
   localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
   localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
   // Register value left after running the CRC over a frame plus its own valid FCS
   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
   localparam int unsigned FCS_BYTES   = 4;

endpackage

// File: rtl/rxecrc_byte.sv
// Combinational next-state function of the reflected CRC-32 register for one byte.
// Shared by the receive checker and the transmit generator.
module rxecrc_byte
   import rxecrc_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [7:0]  d,
   output logic [31:0] crc_out
);

   // Eight unrolled single-bit LFSR steps, data bit 0 first.
   always_comb begin
      crc_out = crc_in;
      for (int i = 0; i < 8; i++) begin
         if (crc_out[0] ^ d[i]) begin
            crc_out = (crc_out >> 1) ^ CRC_POLY;
         end else begin
            crc_out = crc_out >> 1;
         end
      end
   end

endmodule

// File: rtl/rxecrc.sv
// Receive CRC check and FCS strip. Sits after the preamble stripper and feeds the
// address filter / packet buffer. The last FCS_BYTES bytes of every frame are held
// back in a delay line and never forwarded; o_err reports a bad frame at its end.
// Build option: define RXECRC_MINLEN_EN to also flag frames shorter than MINLEN.
module rxecrc
   import rxecrc_pkg::*;
#(
   parameter int unsigned LGCOUNT = 11,
   parameter int unsigned MINLEN  = 64
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_ce,
   input  logic       i_en,
   input  logic       i_v,
   input  logic [7:0] i_d,
   output logic       o_v,
   output logic [7:0] o_d,
   output logic       o_err
);

   logic [31:0]        crc_q;
   logic [31:0]        crc_next;
   logic [LGCOUNT-1:0] count_q;
   logic [2:0]         fill_q;
   // dly_q[0] is the newest byte, dly_q[3] the oldest
   logic [3:0][7:0]    dly_q;
   logic               frame_bad;

   rxecrc_byte u_crc_byte (
      .crc_in  (crc_q),
      .d       (i_d),
      .crc_out (crc_next)
   );

`ifdef RXECRC_MINLEN_EN
   // MINLEN wider than the counter is truncated; keep it below 2**LGCOUNT.
   assign frame_bad = (crc_q != CRC_RESIDUE)
                   || (count_q < LGCOUNT'(FCS_BYTES))
                   || (count_q < LGCOUNT'(MINLEN));
`else
   assign frame_bad = (crc_q != CRC_RESIDUE) || (count_q < LGCOUNT'(FCS_BYTES));

   logic unused_minlen;
   assign unused_minlen = ^MINLEN;
`endif

   // Byte-rate datapath: CRC accumulate, FCS delay line, frame length and error flag.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_v     <= 1'b0;
         o_d     <= 8'h00;
         o_err   <= 1'b0;
         crc_q   <= CRC_INIT;
         count_q <= '0;
         fill_q  <= '0;
         dly_q   <= '0;
      end else if (i_ce) begin
         if (!i_en) begin
            // Bypass: straight pass with one byte of latency, checker kept idle
            o_v     <= i_v;
            o_d     <= i_v ? i_d : 8'h00;
            o_err   <= 1'b0;
            crc_q   <= CRC_INIT;
            count_q <= '0;
            fill_q  <= '0;
            dly_q   <= '0;
         end else if (i_v) begin
            crc_q <= crc_next;
            o_err <= 1'b0;
            dly_q <= {dly_q[2:0], i_d};
            if (count_q != {LGCOUNT{1'b1}}) begin
               count_q <= count_q + LGCOUNT'(1);
            end
            if (fill_q == 3'(FCS_BYTES)) begin
               o_v <= 1'b1;
               o_d <= dly_q[3];
            end else begin
               o_v    <= 1'b0;
               o_d    <= 8'h00;
               fill_q <= fill_q + 3'd1;
            end
         end else begin
            o_v <= 1'b0;
            o_d <= 8'h00;
            // End of frame; in the idle gap o_err simply holds
            if (count_q != '0) begin
               o_err   <= frame_bad;
               crc_q   <= CRC_INIT;
               count_q <= '0;
               fill_q  <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_rxecrc.sv
// Self-checking bench for rxecrc: fixed frame table, hand-written reset and
// minimum-length sequences, then random frames against a frame-level model.
module tb_rxecrc;

`ifdef RXECRC_MINLEN_EN
   localparam bit MinLenOn = 1'b1;
`else
   localparam bit MinLenOn = 1'b0;
`endif
   localparam int MinLen = 64;

   logic       i_clk = 1'b0;
   logic       i_reset;
   logic       i_ce;
   logic       i_en;
   logic       i_v;
   logic [7:0] i_d;
   logic       o_v;
   logic [7:0] o_d;
   logic       o_err;

   rxecrc dut (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_ce    (i_ce),
      .i_en    (i_en),
      .i_v     (i_v),
      .i_d     (i_d),
      .o_v     (o_v),
      .o_d     (o_d),
      .o_err   (o_err)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      string        name;
      int           n;
      logic [127:0] data;   // byte 0 in the top byte
      int           period; // one i_ce every 'period' clocks
      bit           en;
      bit           err;
   } vec_t;

   vec_t       tbl[5];
   logic [7:0] cur_frame[$];
   logic [7:0] exp_fwd[$];
   logic [7:0] got[$];
   int         n_tests = 0;
   int         n_fail  = 0;
   int         viol;
   int         ce_idx;
   int         first_idx;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference CRC-32 of the first m bytes of cur_frame (value sent as FCS).
   function automatic logic [31:0] crc32_of(input int m);
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      for (int i = 0; i < m; i++) begin
         c = c ^ {24'h0, cur_frame[i]};
         for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return ~c;
   endfunction

   // Frame-level model: bad if too short or FCS does not match payload.
   function automatic bit model_err(input bit en);
      int          n;
      logic [31:0] fcs;
      n = cur_frame.size();
      if (!en) return 1'b0;
      if (n < 4) return 1'b1;
      if (MinLenOn && n < MinLen) return 1'b1;
      fcs = {cur_frame[n-1], cur_frame[n-2], cur_frame[n-3], cur_frame[n-4]};
      return crc32_of(n - 4) != fcs;
   endfunction

   function automatic void model_fwd(input bit en);
      int nf;
      exp_fwd.delete();
      nf = en ? ((cur_frame.size() >= 4) ? cur_frame.size() - 4 : 0) : cur_frame.size();
      for (int k = 0; k < nf; k++) exp_fwd.push_back(cur_frame[k]);
   endfunction

   // One clock: drive inputs, sample #1 after the edge, check per-cycle invariants.
   task automatic step(input logic v, input logic [7:0] d, input logic ce);
      logic       pv;
      logic [7:0] pd;
      pv   = o_v;
      pd   = o_d;
      i_v  = v;
      i_d  = d;
      i_ce = ce;
      @(posedge i_clk);
      #1;
      if (!ce && (o_v !== pv || o_d !== pd)) viol++;
      if (o_v !== 1'b1 && o_d !== 8'h00) viol++;
      if (o_v === 1'b1 && o_err !== 1'b0) viol++;
      if (ce) begin
         ce_idx++;
         if (o_v === 1'b1) begin
            got.push_back(o_d);
            if (first_idx < 0) first_idx = ce_idx;
         end
      end
   endtask

   task automatic run_frame(input string tag, input int period, input bit en, input bit exp_err);
      int mism;
      int exp_first;
      i_en      = en;
      got.delete();
      viol      = 0;
      ce_idx    = 0;
      first_idx = -1;
      foreach (cur_frame[k]) begin
         for (int w = 1; w < period; w++) step(1'b1, cur_frame[k], 1'b0);
         step(1'b1, cur_frame[k], 1'b1);
         if (k == 0) check({tag, "/err_clr"}, o_err, 0);
      end
      for (int w = 1; w < period; w++) step(1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b1);
      check({tag, "/err"}, o_err, exp_err);
      for (int g = 0; g < 3 * period; g++) step(1'b0, 8'h00, (g % period) == 0);
      check({tag, "/err_hold"}, o_err, exp_err);
      check({tag, "/nfwd"}, got.size(), exp_fwd.size());
      mism = 0;
      for (int k = 0; k < exp_fwd.size() && k < got.size(); k++)
         if (got[k] !== exp_fwd[k]) mism++;
      check({tag, "/data"}, mism, 0);
      exp_first = !en ? 1 : (exp_fwd.size() > 0 ? 5 : -1);
      check({tag, "/first"}, first_idx, exp_first);
      check({tag, "/inv"}, viol, 0);
   endtask

   initial begin
      int          len;
      int          pos;
      bit          en;
      logic [31:0] f;

      tbl[0] = '{"good", 13, {72'h313233343536373839, 32'h2639F4CB, 24'h0}, 1, 1'b1, 1'b0};
      tbl[1] = '{"corrupt", 13, {72'h313233343436373839, 32'h2639F4CB, 24'h0}, 1, 1'b1, 1'b1};
      tbl[2] = '{"runt", 3, {24'hAABBCC, 104'h0}, 1, 1'b1, 1'b1};
      tbl[3] = '{"throttle", 13, {72'h313233343536373839, 32'h2639F4CB, 24'h0}, 4, 1'b1, 1'b0};
      tbl[4] = '{"bypass", 6, {48'h010203040506, 80'h0}, 1, 1'b0, 1'b0};

      i_reset = 1'b1;
      i_en    = 1'b1;
      i_ce    = 1'b0;
      i_v     = 1'b0;
      i_d     = 8'h00;
      step(1'b1, 8'h5A, 1'b1);
      step(1'b1, 8'hA5, 1'b1);
      i_reset = 1'b0;
      check("reset/o_v", o_v, 0);
      check("reset/o_d", o_d, 0);
      check("reset/o_err", o_err, 0);

      for (int t = 0; t < 5; t++) begin
         cur_frame.delete();
         for (int k = 0; k < tbl[t].n; k++) cur_frame.push_back(tbl[t].data[8*(15-k) +: 8]);
         model_fwd(tbl[t].en);
         run_frame(tbl[t].name, tbl[t].period, tbl[t].en,
                   tbl[t].en && (tbl[t].err || (MinLenOn && tbl[t].n < MinLen)));
      end

      // Reset on byte index 6 of the good frame; remaining bytes form a new frame
      i_en = 1'b1;
      for (int k = 0; k < 6; k++) step(1'b1, tbl[0].data[8*(15-k) +: 8], 1'b1);
      i_reset = 1'b1;
      step(1'b1, 8'h37, 1'b1);
      i_reset = 1'b0;
      check("midrst/o_v", o_v, 0);
      check("midrst/o_d", o_d, 0);
      check("midrst/o_err", o_err, 0);
      cur_frame = '{8'h38, 8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};
      exp_fwd   = '{8'h38, 8'h39};
      run_frame("rst_tail", 1, 1'b1, 1'b1);

      // 60-byte frame with a valid FCS: short only when the length check is built
      cur_frame.delete();
      for (int k = 0; k < 56; k++) cur_frame.push_back(8'($urandom));
      f = crc32_of(56);
      for (int b = 0; b < 4; b++) cur_frame.push_back(f[8*b +: 8]);
      model_fwd(1'b1);
      run_frame("len60", 1, 1'b1, MinLenOn);

      // Random frames: valid, single-byte corrupted, or raw garbage
      for (int r = 0; r < 24; r++) begin
         len = $urandom_range(80, 1);
         en  = ($urandom_range(7, 0) != 0);
         cur_frame.delete();
         if (len >= 5 && $urandom_range(2, 0) != 0) begin
            for (int k = 0; k < len - 4; k++) cur_frame.push_back(8'($urandom));
            f = crc32_of(len - 4);
            for (int b = 0; b < 4; b++) cur_frame.push_back(f[8*b +: 8]);
            if ($urandom_range(1, 0) != 0) begin
               pos = $urandom_range(len - 1, 0);
               cur_frame[pos] = cur_frame[pos] ^ 8'($urandom_range(255, 1));
            end
         end else begin
            for (int k = 0; k < len; k++) cur_frame.push_back(8'($urandom));
         end
         model_fwd(en);
         run_frame($sformatf("rand%0d", r), $urandom_range(3, 1), en, model_err(en));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
